// File: rtl/lcd_nibble_writer.sv
// Writes one byte plus RS to a 4-bit HD44780-style LCD bus, high nibble first, with all bus
// timing measured in ticks from an external interval timer that this block enables while busy.
module lcd_nibble_writer #(
    parameter int SETUP_TICKS     = 1,
    parameter int E_HIGH_TICKS    = 1,
    parameter int HOLD_TICKS      = 1,
    parameter int EXEC_TICKS      = 1,
    parameter int LONG_EXEC_TICKS = 17
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       rs_in,
    input  logic       timer_tick,
    output logic       timer_enable,
    output logic       ready,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_data
);

    typedef enum logic [2:0] {
        IDLE,
        SU_HI,
        EH_HI,
        HD_HI,
        SU_LO,
        EH_LO,
        HD_LO,
        EXEC
    } state_t;

    // Each timed state exits on the tick seen while tick_cnt equals (N-1); N=0 behaves as N=1.
    localparam logic [7:0] SU_LAST   = (SETUP_TICKS     <= 1) ? 8'd0 : 8'(SETUP_TICKS - 1);
    localparam logic [7:0] EH_LAST   = (E_HIGH_TICKS    <= 1) ? 8'd0 : 8'(E_HIGH_TICKS - 1);
    localparam logic [7:0] HD_LAST   = (HOLD_TICKS      <= 1) ? 8'd0 : 8'(HOLD_TICKS - 1);
    localparam logic [7:0] EX_LAST   = (EXEC_TICKS      <= 1) ? 8'd0 : 8'(EXEC_TICKS - 1);
    localparam logic [7:0] LONG_LAST = (LONG_EXEC_TICKS <= 1) ? 8'd0 : 8'(LONG_EXEC_TICKS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tick_cnt;
    logic [7:0] byte_q;
    logic [7:0] byte_nxt;
    logic       rs_q;
    logic       rs_nxt;
    logic [7:0] cur_last;
    logic       long_cmd;
    logic       tick_last;

    // Clear display and return home need the long execution wait.
    assign long_cmd  = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);
    assign tick_last = timer_tick && (tick_cnt == cur_last);
    assign lcd_rw    = 1'b0;

    always_comb begin
        cur_last = 8'd0;
        case (state)
            SU_HI, SU_LO: cur_last = SU_LAST;
            EH_HI, EH_LO: cur_last = EH_LAST;
            HD_HI, HD_LO: cur_last = HD_LAST;
            EXEC:         cur_last = long_cmd ? LONG_LAST : EX_LAST;
            default:      cur_last = 8'd0;
        endcase
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        byte_nxt  = byte_q;
        rs_nxt    = rs_q;
        if (state == IDLE) begin
            if (start) begin
                state_nxt = SU_HI;
                byte_nxt  = data_in;
                rs_nxt    = rs_in;
            end
        end else if (tick_last) begin
            case (state)
                SU_HI:   state_nxt = EH_HI;
                EH_HI:   state_nxt = HD_HI;
                HD_HI:   state_nxt = SU_LO;
                SU_LO:   state_nxt = EH_LO;
                EH_LO:   state_nxt = HD_LO;
                HD_LO:   state_nxt = EXEC;
                EXEC:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change together with the state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state        <= IDLE;
            tick_cnt     <= 8'd0;
            byte_q       <= 8'd0;
            rs_q         <= 1'b0;
            timer_enable <= 1'b0;
            ready        <= 1'b1;
            done         <= 1'b0;
            lcd_e        <= 1'b0;
            lcd_rs       <= 1'b0;
            lcd_data     <= 4'd0;
        end else begin
            state  <= state_nxt;
            byte_q <= byte_nxt;
            rs_q   <= rs_nxt;

            if (state_nxt != state) begin
                tick_cnt <= 8'd0;
            end else if (timer_tick && state != IDLE) begin
                tick_cnt <= tick_cnt + 8'd1;
            end

            timer_enable <= (state_nxt != IDLE);
            ready        <= (state_nxt == IDLE);
            done         <= (state == EXEC) && (state_nxt == IDLE);
            lcd_e        <= (state_nxt == EH_HI) || (state_nxt == EH_LO);

            case (state_nxt)
                SU_HI, EH_HI, HD_HI:       lcd_data <= byte_nxt[7:4];
                SU_LO, EH_LO, HD_LO, EXEC: lcd_data <= byte_nxt[3:0];
                default:                   lcd_data <= lcd_data;
            endcase

            if (state_nxt != IDLE) begin
                lcd_rs <= rs_nxt;
            end
        end
    end

endmodule
